// File: rtl/mem_mmio_responder_pkg.sv
// Memory map shared by the responder and anything that decodes core addresses:
// the MMIO page location, register offsets and console status bit positions.
package mem_map_pkg;

  localparam logic [23:0] MMIO_BASE_HI = 24'hFFFFFF;

  localparam logic [7:0] CONSOLE_DATA_OFS   = 8'h00;
  localparam logic [7:0] CONSOLE_STATUS_OFS = 8'h04;
  localparam logic [7:0] CYCLE_COUNT_OFS    = 8'h08;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

endpackage

// File: rtl/mem_mmio_responder_if.sv
// Core memory port plus the console output stream, bundled for the responder.
// master = core/consumer side, slave = mem_mmio_responder.
interface mem_mmio_responder_if;

  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  modport master (
    output adr, writedata, memwrite, out_ready,
    input  readdata, out_valid, out_data
  );

  modport slave (
    input  adr, writedata, memwrite, out_ready,
    output readdata, out_valid, out_data
  );

endinterface

// File: rtl/mem_mmio_responder_console_fifo.sv
// Pointer-plus-count FIFO for console output. The head word is kept in its own
// register so it has a defined reset value and no path from the push side.
module console_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear_ovf,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_next;
  logic [CW-1:0]    count;
  logic             push_ok, pop_ok, head_load;
  logic [WIDTH-1:0] head_next;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A push into a full FIFO still lands when the head leaves in the same edge.
  assign pop_ok      = pop && !empty;
  assign push_ok     = push && (!full || pop_ok);
  assign rd_ptr_next = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
  assign head_load   = pop_ok || (push_ok && empty);
  assign head_next   = (push_ok && (rd_ptr_next == wr_ptr)) ? din : mem[rd_ptr_next];

  // NOTE: storage has no reset; validity is tracked by count, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // NOTE: every register update uses <= so all state samples the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_next;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
      if (head_load) head <= head_next;
      if (push && full && !pop_ok) overflow <= 1'b1;
      else if (clear_ovf)          overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_mmio_responder.sv
// Responder for the multicycle core's unified memory port: word RAM with
// combinational reads, plus an MMIO page with console FIFO and cycle counter.
module mem_mmio_responder
  import mem_map_pkg::*;
#(
  parameter int    MEM_WORDS  = 64,
  parameter int    FIFO_DEPTH = 4,
  parameter string INIT_FILE  = "memfile.dat"
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_mmio_responder_if.slave  bus
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   ram [MEM_WORDS];
  logic [AW-1:0] ram_idx;
  logic [7:0]    ofs;
  logic          mmio_sel, ram_we, push, clear_ovf, cyc_load;
  logic          fifo_full, fifo_empty, fifo_ovf;
  logic [31:0]   cycle_count;

  assign mmio_sel  = (bus.adr[31:8] == MMIO_BASE_HI);
  assign ofs       = bus.adr[7:0];
  assign ram_idx   = bus.adr[AW+1:2];
  assign ram_we    = bus.memwrite && !mmio_sel;
  assign push      = bus.memwrite && mmio_sel && (ofs == CONSOLE_DATA_OFS);
  assign clear_ovf = bus.memwrite && mmio_sel && (ofs == CONSOLE_STATUS_OFS);
  assign cyc_load  = bus.memwrite && mmio_sel && (ofs == CYCLE_COUNT_OFS);

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= bus.writedata;
  end

  // A load takes priority over the increment on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         cycle_count <= '0;
    else if (cyc_load) cycle_count <= bus.writedata;
    else               cycle_count <= cycle_count + 32'd1;
  end

  console_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (bus.out_ready),
    .clear_ovf (clear_ovf),
    .din       (bus.writedata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (bus.out_data),
    .overflow  (fifo_ovf)
  );

  assign bus.out_valid = !fifo_empty;

  // NOTE: readdata gets a default before the case so no path can infer a latch.
  always_comb begin
    bus.readdata = '0;
    if (!mmio_sel) begin
      bus.readdata = ram[ram_idx];
    end else begin
      case (ofs)
        CONSOLE_STATUS_OFS: begin
          bus.readdata[STAT_EMPTY] = fifo_empty;
          bus.readdata[STAT_FULL]  = fifo_full;
          bus.readdata[STAT_OVF]   = fifo_ovf;
        end
        CYCLE_COUNT_OFS: bus.readdata = cycle_count;
        default:         bus.readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_mmio_responder.sv
// Directed bench for mem_mmio_responder: a reference model of FIFO, overflow and
// cycle counter plus a scoreboard queue of expected console words.
module tb_mem_mmio_responder;

  localparam logic [31:0] A_DATA = 32'hFFFF_FF00;
  localparam logic [31:0] A_STAT = 32'hFFFF_FF04;
  localparam logic [31:0] A_CYC  = 32'hFFFF_FF08;
  localparam int          DEPTH  = 4;

  logic clk;
  logic reset;

  mem_mmio_responder_if bus ();

  mem_mmio_responder #(
    .MEM_WORDS  (64),
    .FIFO_DEPTH (DEPTH),
    .INIT_FILE  ("")
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_cyc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {29'b0, m_ovf, sb.size() == DEPTH, sb.size() == 0};
  endfunction

  // Checks the stream, updates the model with the inputs about to be sampled,
  // then advances one edge and settles 1 time unit past it.
  task automatic step();
    int   pre;
    logic do_pop, do_push, mmio;
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, sb.size() != 0});
    if (sb.size() != 0) check("out_data", bus.out_data, sb[0]);
    if (!reset) begin
      pre     = sb.size();
      mmio    = bus.memwrite && (bus.adr[31:8] == 24'hFFFFFF);
      do_pop  = (pre != 0) && bus.out_ready;
      do_push = mmio && (bus.adr[7:0] == 8'h00);
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        if (pre < DEPTH || do_pop) sb.push_back(bus.writedata);
        else                       m_ovf = 1'b1;
      end
      if (mmio && bus.adr[7:0] == 8'h04) m_ovf = 1'b0;
      m_cyc = (mmio && bus.adr[7:0] == 8'h08) ? bus.writedata : m_cyc + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.adr       = a;
    bus.writedata = d;
    bus.memwrite  = 1'b1;
    step();
    bus.memwrite  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.memwrite = 1'b0;
    bus.adr      = a;
    #1;
    check(tag, bus.readdata, exp);
  endtask

  initial begin
    reset         = 1'b1;
    bus.adr       = '0;
    bus.writedata = '0;
    bus.memwrite  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    rd("rst_status", A_STAT, 32'h1);
    rd("rst_cycle", A_CYC, 32'd0);
    step();
    step();
    reset = 1'b0;

    // cycle counter counts edges since reset release
    step();
    step();
    step();
    rd("cycle_n", A_CYC, m_cyc);

    // RAM store/load, wrap, read-during-write
    wr(32'h0000_0010, 32'h1111_1111);
    bus.adr       = 32'h0000_0010;
    bus.writedata = 32'hDEAD_BEEF;
    bus.memwrite  = 1'b1;
    #1;
    check("ram_rdw_old", bus.readdata, 32'h1111_1111);
    step();
    bus.memwrite = 1'b0;
    rd("ram_load", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_wrap", 32'h0000_0110, 32'hDEAD_BEEF);
    rd("ram_unaligned", 32'h0000_0013, 32'hDEAD_BEEF);

    // console ordering
    wr(A_DATA, 32'd1);
    wr(A_DATA, 32'd2);
    wr(A_DATA, 32'd3);
    rd("order_status", A_STAT, 32'h0);
    check("order_head", bus.out_data, 32'd1);
    bus.out_ready = 1'b1;
    repeat (4) step();
    rd("order_drained", A_STAT, 32'h1);
    bus.out_ready = 1'b0;

    // overflow on the fifth push, sticky until a status write
    for (int i = 0; i < 5; i++) wr(A_DATA, 32'd10 + 32'(i));
    rd("ovf_status", A_STAT, 32'h6);
    check("ovf_head", bus.out_data, 32'd10);
    wr(A_STAT, 32'h0);
    rd("ovf_cleared", A_STAT, 32'h2);
    bus.out_ready = 1'b1;
    repeat (5) step();
    rd("ovf_drained", A_STAT, exp_status());
    bus.out_ready = 1'b0;

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) wr(A_DATA, 32'd20 + 32'(i));
    bus.out_ready = 1'b1;
    wr(A_DATA, 32'hA5);
    rd("fullpp_status", A_STAT, 32'h2);
    repeat (5) step();
    check("fullpp_empty", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;

    // cycle counter load and wrap
    wr(A_CYC, 32'hFFFF_FFFE);
    rd("cyc_load", A_CYC, 32'hFFFF_FFFE);
    step();
    rd("cyc_max", A_CYC, 32'hFFFF_FFFF);
    step();
    rd("cyc_wrap", A_CYC, 32'h0000_0000);

    // asynchronous reset with two words queued and overflow set
    for (int i = 0; i < 5; i++) wr(A_DATA, 32'd30 + 32'(i));
    bus.out_ready = 1'b1;
    step();
    step();
    check("pre_rst_count", 32'(sb.size()), 32'd2);
    rd("pre_rst_status", A_STAT, 32'h4);
    reset = 1'b1;
    sb.delete();
    m_ovf = 1'b0;
    m_cyc = '0;
    #1;
    check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("arst_out_data", bus.out_data, 32'd0);
    rd("arst_status", A_STAT, 32'h1);
    rd("arst_cycle", A_CYC, 32'd0);
    rd("arst_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
    step();
    step();
    reset = 1'b0;
    bus.out_ready = 1'b0;
    step();
    rd("post_rst_cycle", A_CYC, m_cyc);
    rd("post_rst_status", A_STAT, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
